// File: rtl/cpu_debug_ctrl_if.sv
// Core-side bus of the run/halt/step controller: PC/trap inputs, stall/commit
// outputs and the breakpoint register write port.
interface cpu_debug_ctrl_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NUM_BP = 4
);
    localparam int unsigned IdxW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    logic [XLEN-1:0] pc;
    logic            is_debug;
    logic            stall;
    logic            commit_en;
    logic            bp_wr_en;
    logic [IdxW-1:0] bp_wr_idx;
    logic [XLEN-1:0] bp_wr_addr;
    logic            bp_wr_valid;

    modport master (
        output pc, is_debug, bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid,
        input  stall, commit_en
    );

    modport slave (
        input  pc, is_debug, bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid,
        output stall, commit_en
    );
endinterface

// File: rtl/cpu_debug_ctrl.sv
// Run/halt/step controller for the RV64 single-cycle core: debounced continue
// key, NUM_BP PC breakpoints, N-instruction stepping, halt cause/PC reporting.
// Optional: define HALT_CNT_EN to build the 32-bit halt-entry counter.
module cpu_debug_ctrl #(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned NUM_BP          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              continue_key,
    input  logic              step_mode,
    input  logic [STEP_W-1:0] step_count,
    cpu_debug_ctrl_if.slave   bus,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [XLEN-1:0]   halt_pc,
    output logic [31:0]       halt_cnt
);
    localparam int unsigned IdxW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {StRun, StHalt, StStep} state_e;

    state_e            state_q, state_d;
    logic              mask_q, mask_d;
    logic              pend_q, pend_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [XLEN-1:0]   hpc_q, hpc_d;

    logic [1:0]        sync_q;
    logic              key_level_q;
    logic              cont_pulse_q;
    logic [DbW-1:0]    db_cnt_q;

    logic [NUM_BP-1:0] bp_valid_q;
    logic [XLEN-1:0]   bp_addr_q [NUM_BP];

    logic              bp_hit;
    logic              trig;
    logic              fire;
    logic [1:0]        trig_cause;
    logic              stall;

    // Key synchroniser and debouncer; one-cycle pulse on the accepted rising level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= '0;
            key_level_q  <= 1'b0;
            cont_pulse_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync_q       <= {sync_q[0], continue_key};
            cont_pulse_q <= 1'b0;
            if (sync_q[1] == key_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q     <= '0;
                key_level_q  <= sync_q[1];
                cont_pulse_q <= sync_q[1];
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // Breakpoint registers; out-of-range slot indices are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (bus.bp_wr_en && (bus.bp_wr_idx == IdxW'(i))) begin
                    bp_valid_q[i] <= bus.bp_wr_valid;
                    bp_addr_q[i]  <= bus.bp_wr_addr;
                end
            end
        end
    end

    // Trigger: debug trap or any valid breakpoint matching the current PC.
    always_comb begin
        bp_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            bp_hit = bp_hit | (bp_valid_q[i] & (bus.pc == bp_addr_q[i]));
        end
    end

    assign trig       = bus.is_debug | bp_hit;
    assign trig_cause = bus.is_debug ? 2'd1 : 2'd2;
    assign fire       = trig & ~mask_q;

    // Next-state logic; mask lets the halting instruction execute once on resume.
    always_comb begin
        state_d = state_q;
        mask_d  = 1'b0;
        pend_d  = 1'b0;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        hpc_d   = pend_q ? bus.pc : hpc_q;
        stall   = 1'b0;
        case (state_q)
            StRun: begin
                stall = fire;
                if (fire) begin
                    state_d = StHalt;
                    cause_d = trig_cause;
                    hpc_d   = bus.pc;
                end
            end
            StHalt: begin
                stall = 1'b1;
                if (cont_pulse_q) begin
                    mask_d = 1'b1;
                    if (step_mode) begin
                        state_d = StStep;
                        cnt_d   = (step_count == '0) ? STEP_W'(1) : step_count;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StStep: begin
                stall = fire;
                if (fire) begin
                    state_d = StHalt;
                    cause_d = trig_cause;
                    hpc_d   = bus.pc;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == STEP_W'(1)) begin
                        // Halt PC is the next instruction, captured one cycle later.
                        state_d = StHalt;
                        cause_d = 2'd3;
                        pend_d  = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            mask_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            cause_q <= 2'd0;
            hpc_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            hpc_q   <= hpc_d;
        end
    end

`ifdef HALT_CNT_EN
    logic        halt_entry;
    logic [31:0] halt_cnt_q;

    assign halt_entry = (state_d == StHalt) && (state_q != StHalt);

    // Halt-entry counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_cnt_q <= '0;
        end else if (halt_entry) begin
            halt_cnt_q <= halt_cnt_q + 32'd1;
        end
    end

    assign halt_cnt = halt_cnt_q;
`else
    assign halt_cnt = '0;
`endif

    assign bus.stall     = stall;
    assign bus.commit_en = ~stall;
    assign halted        = (state_q == StHalt);
    assign halt_cause    = cause_q;
    assign halt_pc       = hpc_q;
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: table of halt scenarios, directed multi-cycle
// sequences and a random run, all checked every cycle against a behavioural model.
module tb_cpu_debug_ctrl;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned NUM_BP = 4;
    localparam int unsigned DB     = 16;
    localparam int unsigned STEP_W = 8;
`ifdef HALT_CNT_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              continue_key = 1'b0;
    logic              step_mode = 1'b0;
    logic [STEP_W-1:0] step_count = '0;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [XLEN-1:0]   halt_pc;
    logic [31:0]       halt_cnt;

    cpu_debug_ctrl_if #(.XLEN(XLEN), .NUM_BP(NUM_BP)) bus ();

    cpu_debug_ctrl #(
        .XLEN(XLEN), .NUM_BP(NUM_BP), .DEBOUNCE_CYCLES(DB), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .rst(rst), .continue_key(continue_key), .step_mode(step_mode),
        .step_count(step_count), .bus(bus), .halted(halted), .halt_cause(halt_cause),
        .halt_pc(halt_pc), .halt_cnt(halt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_halted, m_skip, m_pend, m_pulse, m_level;
    int          m_budget;   // instructions left in a step run, 0 = free running
    int          m_run;      // consecutive debounced samples differing from level
    logic [1:0]  m_cause;
    logic [63:0] m_hpc;
    int unsigned m_cnt;
    bit          m_bpv [NUM_BP];
    logic [63:0] m_bpa [NUM_BP];
    bit          raw_q [$];

    // Core emulation
    bit          core_run;
    bit          dbg_en;
    logic [63:0] dbg_pc;
    bit          exp_stall;
    bit          act_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_skip = 0; m_pend = 0; m_pulse = 0; m_level = 0;
        m_budget = 0; m_run = 0; m_cause = 0; m_hpc = 0; m_cnt = 0;
        for (int i = 0; i < NUM_BP; i++) begin
            m_bpv[i] = 0;
            m_bpa[i] = 0;
        end
        raw_q.delete();
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        continue_key = 1'b0;
        bus.pc = '0; bus.is_debug = 1'b0; bus.bp_wr_en = 1'b0;
        bus.bp_wr_idx = '0; bus.bp_wr_addr = '0; bus.bp_wr_valid = 1'b0;
        core_run = 0; dbg_en = 0; dbg_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // One clock: check at the negedge, advance the model, then drive after the edge.
    task automatic cycle();
        bit trig, fire, samp;
        #4;
        trig = bus.is_debug;
        for (int i = 0; i < NUM_BP; i++) if (m_bpv[i] && m_bpa[i] == bus.pc) trig = 1;
        fire = trig && !m_skip;
        exp_stall = m_halted || fire;
        act_stall = bus.stall;
        chk("stall", bus.stall, exp_stall);
        chk("commit_en", bus.commit_en, !exp_stall);
        chk("halted", halted, m_halted);
        chk("halt_cause", halt_cause, m_cause);
        chk("halt_pc", halt_pc, m_hpc);
        chk("halt_cnt", halt_cnt, HC ? m_cnt : 0);

        if (m_pend) begin
            m_hpc  = bus.pc;
            m_pend = 0;
        end
        if (m_halted) begin
            if (m_pulse) begin
                m_halted = 0;
                m_skip   = 1;
                m_budget = !step_mode ? 0 : (step_count == 0) ? 1 : int'(step_count);
            end
        end else begin
            m_skip = 0;
            if (fire) begin
                m_halted = 1;
                m_cause  = bus.is_debug ? 2'd1 : 2'd2;
                m_hpc    = bus.pc;
                m_budget = 0;
                m_cnt++;
            end else if (m_budget > 0) begin
                m_budget--;
                if (m_budget == 0) begin
                    m_halted = 1;
                    m_cause  = 2'd3;
                    m_pend   = 1;
                    m_cnt++;
                end
            end
        end
        if (bus.bp_wr_en && int'(bus.bp_wr_idx) < NUM_BP) begin
            m_bpv[bus.bp_wr_idx] = bus.bp_wr_valid;
            m_bpa[bus.bp_wr_idx] = bus.bp_wr_addr;
        end
        // Key: raw sample reaches the debouncer two edges later.
        raw_q.push_back(continue_key);
        samp = raw_q[raw_q.size() - 3];
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        m_pulse = 0;
        if (samp != m_level) begin
            m_run++;
            if (m_run == DB) begin
                m_level = samp;
                m_run   = 0;
                m_pulse = samp;
            end
        end else begin
            m_run = 0;
        end

        @(posedge clk);
        #1;
        if (core_run && !exp_stall) bus.pc = bus.pc + 64'd4;
        bus.is_debug = dbg_en && (bus.pc == dbg_pc);
        bus.bp_wr_en = 1'b0;
    endtask

    task automatic bp_write(input int idx, input logic [63:0] addr, input bit valid);
        bus.bp_wr_en    = 1'b1;
        bus.bp_wr_idx   = 2'(idx);
        bus.bp_wr_addr  = addr;
        bus.bp_wr_valid = valid;
        cycle();
    endtask

    task automatic run_until_halt(input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("halt_reached", halted, 1);
    endtask

    // Hold the key until the controller leaves and re-enters HALT; count run cycles.
    task automatic press_and_count(output int run_cycles);
        int  n = 0;
        bit  left = 0;
        run_cycles = 0;
        continue_key = 1'b1;
        while (n < 100) begin
            cycle();
            n++;
            if (!act_stall) run_cycles++;
            if (!halted) left = 1;
            if (left && halted) break;
        end
        chk("rehalt_reached", halted, 1);
        continue_key = 1'b0;
    endtask

    typedef struct {
        int          slot;
        logic [63:0] addr;
        bit          valid;
        bit          dbg;
        logic [63:0] dbg_pc;
        logic [1:0]  exp_cause;
        logic [63:0] exp_pc;
    } vec_t;

    initial begin
        vec_t vt[5];
        int   nrun, falls;
        bit   prev;
        int   hold;

        vt[0] = '{0, 64'h40, 1, 0, 64'h0,  2'd2, 64'h40};
        vt[1] = '{0, 64'h40, 1, 1, 64'h40, 2'd1, 64'h40};
        vt[2] = '{0, 64'h40, 1, 1, 64'h20, 2'd1, 64'h20};
        vt[3] = '{3, 64'h18, 1, 0, 64'h0,  2'd2, 64'h18};
        vt[4] = '{1, 64'h10, 0, 1, 64'h60, 2'd1, 64'h60};

        do_reset();
        chk("rst_stall", bus.stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_pc", halt_pc, 0);

        // Table: each row halts a free-running core at a known PC with a known cause.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            bp_write(vt[v].slot, vt[v].addr, vt[v].valid);
            dbg_en   = vt[v].dbg;
            dbg_pc   = vt[v].dbg_pc;
            core_run = 1;
            bus.is_debug = dbg_en && (bus.pc == dbg_pc);
            run_until_halt(100);
            chk("tbl_cause", halt_cause, vt[v].exp_cause);
            chk("tbl_halt_pc", halt_pc, vt[v].exp_pc);
            repeat (5) cycle();
            chk("tbl_pc_held", bus.pc, vt[v].exp_pc);
            chk("tbl_commit_off", bus.commit_en, 0);
        end

        // Debug + breakpoint at 0x40, then a 40-cycle press resumes exactly once.
        do_reset();
        bp_write(0, 64'h40, 1);
        dbg_en = 1; dbg_pc = 64'h40; core_run = 1;
        run_until_halt(100);
        chk("dbgbp_cause", halt_cause, 1);
        continue_key = 1'b1;
        falls = 0;
        for (int i = 0; i < 40; i++) begin
            prev = halted;
            cycle();
            if (prev && !halted) falls++;
        end
        continue_key = 1'b0;
        chk("one_resume", falls, 1);
        chk("no_rehalt", halted, 0);
        chk("pc_past_44", bus.pc >= 64'h44, 1);
        repeat (DB + 4) cycle();

        // Bouncing key never settles long enough to resume.
        do_reset();
        bp_write(0, 64'h40, 1);
        core_run = 1;
        run_until_halt(100);
        for (int i = 0; i < 60; i++) begin
            continue_key = ((i / 5) % 2) == 0;
            cycle();
        end
        continue_key = 1'b0;
        repeat (30) cycle();
        chk("bounce_halted", halted, 1);

        // Step 3, then step with count 0 (one instruction).
        do_reset();
        bp_write(0, 64'h40, 1);
        core_run = 1;
        run_until_halt(100);
        step_mode = 1; step_count = 8'd3;
        press_and_count(nrun);
        chk("step3_runs", nrun, 3);
        chk("step3_cause", halt_cause, 3);
        cycle();
        chk("step3_pc", halt_pc, 64'h4C);
        repeat (DB + 4) cycle();
        step_count = 8'd0;
        press_and_count(nrun);
        chk("step0_runs", nrun, 1);
        cycle();
        chk("step0_pc", halt_pc, 64'h50);
        chk("halt_cnt_3", halt_cnt, HC ? 3 : 0);
        repeat (DB + 4) cycle();

        // Breakpoint at 0x44 cuts a 5-step run short.
        do_reset();
        bp_write(0, 64'h40, 1);
        bp_write(1, 64'h44, 1);
        core_run = 1;
        run_until_halt(100);
        step_mode = 1; step_count = 8'd5;
        press_and_count(nrun);
        chk("stepbp_runs", nrun, 1);
        chk("stepbp_cause", halt_cause, 2);
        chk("stepbp_pc", halt_pc, 64'h44);
        repeat (DB + 4) cycle();

        // Asynchronous reset while halted, checked between clock edges.
        rst = 1'b0;
        #1;
        chk("arst_stall", bus.stall, 0);
        chk("arst_halted", halted, 0);
        chk("arst_cause", halt_cause, 0);
        chk("arst_pc", halt_pc, 0);
        do_reset();

        // Random run against the model.
        step_mode = 0;
        core_run = 1;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) bus.pc = 64'($urandom_range(0, 31) * 4);
            bus.is_debug = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.bp_wr_en    = 1'b1;
                bus.bp_wr_idx   = 2'($urandom_range(0, 3));
                bus.bp_wr_addr  = 64'($urandom_range(0, 31) * 4);
                bus.bp_wr_valid = 1'($urandom_range(0, 1));
            end
            if (hold == 0) begin
                continue_key = ~continue_key;
                hold = $urandom_range(1, 40);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 49) == 0) step_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) step_count = 8'($urandom_range(0, 6));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
- Parametrised run/halt/step controller for the RV64 single-cycle core.
- Replaces the ad-hoc pause flop with:
  - a synchronised, debounced continue key
  - NUM_BP hardware PC breakpoints
  - N-instruction single-step mode
  - halt-cause/halt-PC reporting
- Drives the PC stall input and a commit enable that gates register-file and data-memory writes.

Parameters:
- XLEN, 64: PC / breakpoint address width.
- NUM_BP, 4: number of breakpoint comparators (1..16).
- DEBOUNCE_CYCLES, 16: cycles the synchronised key must stay stable before its level is accepted (>=2).
- STEP_W, 8: width of the step-count input.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- continue_key  in  1  raw push-button, high while pressed; asynchronous to clk.
- step_mode  in  1  level; when 1, a continue runs step_count instructions then re-halts.
- step_count  in  STEP_W  instructions per step; 0 is treated as 1.
- is_debug  in  1  decoder flag: the instruction at pc is a debug trap.
- pc  in  XLEN  current PC.
- bp_wr_en  in  1  breakpoint register write strobe.
- bp_wr_idx  in  clog2(NUM_BP) (min 1)  breakpoint slot to write.
- bp_wr_addr  in  XLEN  breakpoint address.
- bp_wr_valid  in  1  enable bit written with the slot.
- stall  out  1  1 = hold PC.
- commit_en  out  1  equals ~stall; core ANDs it into rf_wr_en and the dm write enable.
- halted  out  1  registered; 1 while in HALT.
- halt_cause  out  2  0 none, 1 debug instruction, 2 breakpoint, 3 step done.
- halt_pc  out  XLEN  PC captured on halt entry.
- halt_cnt  out  32  halt-entry counter (see Optional Feature).

Behaviour:
- Reset (rst=0): state RUN, stall=0, halted=0, halt_cause=0, halt_pc=0, all breakpoints invalid, step counter 0, debounce state cleared.
- Key path:
  - 2-flop synchroniser, then debounce counter; the accepted level changes only after DEBOUNCE_CYCLES identical consecutive samples.
  - cont_pulse is one cycle on the accepted 0->1 edge.
  - Latency from a stable press to cont_pulse is 2+DEBOUNCE_CYCLES cycles.
- Trigger: trig = is_debug | (bp_valid[i] & pc==bp_addr[i] for any i). Cause priority: debug (1) over breakpoint (2).
- States:
  - RUN: stall = trig & ~mask, combinational. If trig & ~mask, go to HALT next edge, latch halt_pc=pc and the cause.
  - HALT: stall=1, halted=1. On cont_pulse:
    - step_mode=0: go to RUN with mask=1.
    - step_mode=1: load cnt=max(step_count,1) and go to STEP with mask=1.
  - STEP: stall = trig & ~mask. If trig & ~mask, go to HALT with that trigger's cause. Otherwise each cycle executes one instruction and decrements cnt; when cnt reaches 0, go to HALT with cause 3 and halt_pc = the pc the core advances to, i.e. next cycle's pc, so it is captured on the HALT entry edge + 1.
- mask:
  - Set for exactly the first cycle after leaving HALT, so the halting instruction executes once and is not re-trapped.
  - Cleared otherwise.
- cont_pulse in RUN or STEP is ignored.
- halt_cause and halt_pc hold their values until the next halt entry. Leaving HALT does not clear them.
- Breakpoint writes:
  - Take effect from the next edge.
  - A write in the same cycle as a match on that slot uses the old contents.
  - Writes are allowed in any state.
- Reset asserted mid-HALT or mid-STEP returns the block to RUN immediately (asynchronous), with the reset values above.

Optional Feature:
- HALT_CNT_EN defined: halt_cnt is a 32-bit counter, +1 on each HALT entry, wrapping 0xFFFFFFFF->0, reset to 0.
- HALT_CNT_EN undefined: halt_cnt tied to 0 and no counter flops are built.

Test Plan:
- Breakpoint: bp0=0x40 valid, core runs from 0 -> stall=1 in the cycle pc=0x40; next edge halted=1, halt_cause=2, halt_pc=0x40; commit_en=0 for the whole halt.
- Debug plus breakpoint: is_debug=1 at pc=0x40 with bp0=0x40 also set -> halt_cause=1. Press key for 40 cycles -> exactly one cont_pulse; the instruction at 0x40 executes once, pc reaches 0x44 with no re-halt.
- Debounce: key bounces with 5-cycle pulses for 60 cycles, then stays low -> no cont_pulse; state remains HALT.
- Step: step_mode=1, step_count=3, halted at 0x40 -> exactly 3 cycles with stall=0; re-halt with cause 3, halt_pc=0x4C. step_count=0 -> exactly 1 instruction.
- Breakpoint during step: bp1=0x44 set, step_count=5 from 0x40 -> halt at 0x44 with cause 2.
- Reset in HALT: rst low while halted -> stall=0, halted=0, halt_cause=0 without waiting for a clock edge. With HALT_CNT_EN defined, 3 halts give halt_cnt=3.
